// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Accepts one ALU command at a time, drives it to an external ALU through
// registered operand/opcode outputs, waits SETTLE_CYCLES for the ALU to
// settle, captures the result and flags, then holds them until the consumer
// takes them. A new command may be accepted in the same cycle the held
// result is consumed, so back-to-back operation has no idle bubble.
//
// Ports
//   iClk, iReset              clock, synchronous active-high reset
//   iCmdValid/oCmdReady       command handshake
//   iCmdOp/iCmdA/iCmdB        command opcode and operands
//   oA/oB/oOpCode             registered drive to the ALU
//   iAccu/iCarryFlag/iZeroFlag ALU result and flags
//   oResValid/iResReady       result handshake
//   oResult/oResCarry/oResZero/oResErr  captured result, flags, bad-opcode flag
//   oBusy                     high whenever the sequencer is not idle
//   oOpCount                  completed result handshakes, wraps at 255
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iCmdValid,
    output logic       oCmdReady,
    input  logic [3:0] iCmdOp,
    input  logic [7:0] iCmdA,
    input  logic [7:0] iCmdB,
    output logic [7:0] oA,
    output logic [7:0] oB,
    output logic [3:0] oOpCode,
    input  logic [7:0] iAccu,
    input  logic       iCarryFlag,
    input  logic       iZeroFlag,
    output logic       oResValid,
    input  logic       iResReady,
    output logic [7:0] oResult,
    output logic       oResCarry,
    output logic       oResZero,
    output logic       oResErr,
    output logic       oBusy,
    output logic [7:0] oOpCount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [3:0] op_q, op_d;
    logic [7:0] res_q, res_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic       err_q, err_d;
    logic [7:0] count_q, count_d;

    logic       cmd_ready_s;
    logic       cmd_accept_s;
    logic       res_hs_s;

    // Handshake decode: idle accepts freely, hold accepts only while the result is being consumed
    always_comb begin
        cmd_ready_s  = (state_q == IDLE) || ((state_q == HOLD) && iResReady);
        cmd_accept_s = cmd_ready_s && iCmdValid;
        res_hs_s     = (state_q == HOLD) && iResReady;
    end

    // Next-state logic and settle down-counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept_s) state_d = ISSUE;
                else              state_d = IDLE;
            end
            ISSUE: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_INIT;
            end
            SETTLE: begin
                // Counter holds the SETTLE cycles still to spend, including this one
                if (cnt_q <= 4'd1) begin
                    state_d = CAPTURE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (cmd_accept_s)   state_d = ISSUE;
                else if (iResReady) state_d = IDLE;
                else                state_d = HOLD;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Datapath next values: command registers, result capture, handshake counter
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        count_d = count_q;
        if (cmd_accept_s) begin
            a_d  = iCmdA;
            b_d  = iCmdB;
            op_d = iCmdOp;
        end else begin
            a_d  = a_q;
        end
        if (state_q == CAPTURE) begin
            // Opcodes with the top bit set are not ALU operations: report a clean error result
            if (op_q[3]) begin
                res_d   = 8'h00;
                carry_d = 1'b0;
                zero_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                res_d   = iAccu;
                carry_d = iCarryFlag;
                zero_d  = iZeroFlag;
                err_d   = 1'b0;
            end
        end else begin
            res_d = res_q;
        end
        if (res_hs_s) count_d = count_q + 8'd1;
        else          count_d = count_q;
    end

    // State and datapath registers with synchronous reset taking priority over all handshakes
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= 4'h0;
            res_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Output mapping; status outputs decode directly from the state register
    always_comb begin
        oCmdReady = cmd_ready_s;
        oA        = a_q;
        oB        = b_q;
        oOpCode   = op_q;
        oResult   = res_q;
        oResCarry = carry_q;
        oResZero  = zero_q;
        oResErr   = err_q;
        oResValid = (state_q == HOLD);
        oBusy     = (state_q != IDLE);
        oOpCount  = count_q;
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: commands push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_alu_cmd_sequencer;

    localparam int S = 1;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iCmdValid;
    logic       oCmdReady;
    logic [3:0] iCmdOp;
    logic [7:0] iCmdA, iCmdB;
    logic [7:0] oA, oB;
    logic [3:0] oOpCode;
    logic [7:0] iAccu;
    logic       iCarryFlag, iZeroFlag;
    logic       oResValid;
    logic       iResReady;
    logic [7:0] oResult;
    logic       oResCarry, oResZero, oResErr, oBusy;
    logic [7:0] oOpCount;

    alu_cmd_sequencer #(.SETTLE_CYCLES(S)) dut (
        .iClk(iClk), .iReset(iReset),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iCmdOp(iCmdOp), .iCmdA(iCmdA), .iCmdB(iCmdB),
        .oA(oA), .oB(oB), .oOpCode(oOpCode),
        .iAccu(iAccu), .iCarryFlag(iCarryFlag), .iZeroFlag(iZeroFlag),
        .oResValid(oResValid), .iResReady(iResReady),
        .oResult(oResult), .oResCarry(oResCarry), .oResZero(oResZero),
        .oResErr(oResErr), .oBusy(oBusy), .oOpCount(oOpCount)
    );

    always #5 iClk = ~iClk;

    // Environment ALU: bit-level model driven from the registered outputs.
    // Unsupported opcodes produce junk so the sequencer must override it.
    always_comb begin
        iAccu      = 8'hA5;
        iCarryFlag = 1'b1;
        iZeroFlag  = 1'b0;
        case (oOpCode)
            4'd0: {iCarryFlag, iAccu} = {1'b0, oA & oB};
            4'd1: {iCarryFlag, iAccu} = {1'b0, oA | oB};
            4'd2: {iCarryFlag, iAccu} = {1'b0, oA ^ oB};
            4'd3: {iCarryFlag, iAccu} = {1'b0, ~oA};
            4'd4: {iCarryFlag, iAccu} = {oA, 1'b0};
            4'd5: {iCarryFlag, iAccu} = {1'b0, oA} + {1'b0, oB};
            4'd6: {iAccu, iCarryFlag} = {1'b0, oA};
            4'd7: {iCarryFlag, iAccu} = {1'b0, oA} - {1'b0, oB};
            default: iAccu = 8'hA5;
        endcase
        if (!oOpCode[3]) iZeroFlag = (iAccu == 8'h00);
    end

    // Reference: integer arithmetic; packed as {err, zero, carry, result}
    function automatic logic [10:0] ref_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        logic c;
        ia = int'(a); ib = int'(b); c = 1'b0; r = 0;
        if (op >= 4'd8) return 11'b110_0000_0000;
        case (op)
            4'd0: r = ia & ib;
            4'd1: r = ia | ib;
            4'd2: r = ia ^ ib;
            4'd3: r = 255 - ia;
            4'd4: begin r = ia * 2;  c = (r > 255); end
            4'd5: begin r = ia + ib; c = (r > 255); end
            4'd6: begin r = ia / 2;  c = (ia % 2 == 1); end
            4'd7: begin r = ia - ib; c = (r < 0); end
            default: r = 0;
        endcase
        r = r & 255;
        return {1'b0, (r == 0), c, 8'(r)};
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [10:0] exp;
        int          acc_cyc;
    } txn_t;

    txn_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [7:0]  model_cnt = 8'd0;
    logic [10:0] held;
    logic        prev_valid = 1'b0;
    logic        saw_idle   = 1'b0;
    int          rr_mode    = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Result-ready driver: 0 = stall, 1 = always ready, else random
    initial begin
        iResReady = 1'b0;
        forever begin
            @(posedge iClk); #2;
            case (rr_mode)
                0:       iResReady = 1'b0;
                1:       iResReady = 1'b1;
                default: iResReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor/scoreboard: samples at the falling edge, values hold until the next rising edge
    initial begin
        txn_t e;
        forever begin
            @(negedge iClk);
            cyc++;
            if (!oBusy) saw_idle = 1'b1;
            if (iReset) begin
                exp_q.delete();
                model_cnt  = 8'd0;
                prev_valid = 1'b0;
            end else begin
                if (oResValid) begin
                    if (!prev_valid) begin
                        chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0)
                            chk("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(S + 3));
                        held = {oResErr, oResZero, oResCarry, oResult};
                    end else begin
                        chk("hold_stable", 32'({oResErr, oResZero, oResCarry, oResult}), 32'(held));
                    end
                    chk("cmd_ready_hold", 32'(oCmdReady), 32'(iResReady));
                    if (iResReady && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("result",  32'(oResult),   32'(e.exp[7:0]));
                        chk("carry",   32'(oResCarry), 32'(e.exp[8]));
                        chk("zero",    32'(oResZero),  32'(e.exp[9]));
                        chk("err",     32'(oResErr),   32'(e.exp[10]));
                        chk("drive",   32'({oOpCode, oA, oB}), 32'({e.op, e.a, e.b}));
                        chk("opcount", 32'(oOpCount),  32'(model_cnt));
                        model_cnt = model_cnt + 8'd1;
                    end
                    prev_valid = !iResReady;
                end else begin
                    prev_valid = 1'b0;
                    chk("cmd_ready", 32'(oCmdReady), 32'(!oBusy));
                end
                if (iCmdValid && oCmdReady) begin
                    e.op = iCmdOp; e.a = iCmdA; e.b = iCmdB;
                    e.exp = ref_fn(iCmdOp, iCmdA, iCmdB);
                    e.acc_cyc = cyc;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Present a command and hold it until accepted; returns just after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        iCmdValid = 1'b1; iCmdOp = op; iCmdA = a; iCmdB = b;
        do begin
            @(negedge iClk);
            n++;
        end while (!oCmdReady && n < 200);
        chk("cmd_accepted", 32'(oCmdReady), 32'd1);
        @(posedge iClk); #1;
        iCmdValid = 1'b0;
        iCmdOp = 4'($urandom); iCmdA = 8'($urandom); iCmdB = 8'($urandom);
        if (n >= 200) begin
            $display("FAIL accept_timeout: command never accepted");
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $fatal(1, "accept timeout");
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!oResValid && n < 100);
        chk("valid_seen", 32'(oResValid), 32'd1);
    endtask

    task automatic drain();
        int n;
        rr_mode = 1;
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while ((exp_q.size() != 0 || oResValid) && n < 300);
        chk("drained", 32'(exp_q.size()), 32'd0);
        @(posedge iClk); #1;
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        @(posedge iClk); #1;
        iReset = 1'b0;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge iClk); #1;
            end
            issue(4'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        iReset = 1'b1; iCmdValid = 1'b0; iCmdOp = 4'h0; iCmdA = 8'h00; iCmdB = 8'h00;
        repeat (3) @(posedge iClk);
        #1 iReset = 1'b0;
        @(negedge iClk);
        chk("rst_drive",   32'({oOpCode, oA, oB}), 32'd0);
        chk("rst_result",  32'({oResErr, oResZero, oResCarry, oResult}), 32'd0);
        chk("rst_valid",   32'(oResValid), 32'd0);
        chk("rst_count",   32'(oOpCount), 32'd0);
        chk("rst_busy",    32'(oBusy), 32'd0);
        chk("rst_ready",   32'(oCmdReady), 32'd1);
        @(posedge iClk); #1;

        // ADD with carry out
        rr_mode = 1;
        issue(4'b0101, 8'hF0, 8'h20);
        wait_valid();
        chk("add_result", 32'({oResErr, oResZero, oResCarry, oResult}), 32'({1'b0, 1'b0, 1'b1, 8'h10}));
        drain();
        chk("add_count", 32'(oOpCount), 32'd1);

        // Zero result, consumer stalls
        rr_mode = 0;
        issue(4'b0111, 8'h33, 8'h33);
        wait_valid();
        chk("sub_zero", 32'({oResZero, oResult}), 32'({1'b1, 8'h00}));
        repeat (5) begin
            @(negedge iClk);
            chk("stall_ready", 32'(oCmdReady), 32'd0);
            chk("stall_valid", 32'(oResValid), 32'd1);
        end
        drain();

        // Unsupported opcode, then a supported one clears the error
        issue(4'b1001, 8'h55, 8'h00);
        wait_valid();
        chk("bad_op", 32'({oResErr, oResZero, oResCarry, oResult}), 32'({1'b1, 1'b1, 1'b0, 8'h00}));
        drain();
        issue(4'b0000, 8'hFF, 8'h0F);
        wait_valid();
        chk("and_op", 32'({oResErr, oResult}), 32'({1'b0, 8'h0F}));
        drain();

        // Back-to-back: second accepted in HOLD of first, never idle in between
        issue(4'd1, 8'h12, 8'h34);
        saw_idle = 1'b0;
        issue(4'd2, 8'h0F, 8'hF0);
        chk("b2b_no_idle", 32'(saw_idle), 32'd0);
        drain();
        chk("b2b_count", 32'(oOpCount), 32'(model_cnt));

        // Reset in SETTLE discards the in-flight command
        do_reset();
        issue(4'd5, 8'h01, 8'h02);
        @(posedge iClk); #1;
        iReset = 1'b1;
        @(negedge iClk);
        chk("pre_rst_busy", 32'(oBusy), 32'd1);
        @(posedge iClk); #1;
        iReset = 1'b0;
        @(negedge iClk);
        chk("mid_rst_busy",  32'(oBusy), 32'd0);
        chk("mid_rst_valid", 32'(oResValid), 32'd0);
        chk("mid_rst_outs",  32'({oOpCode, oA, oB}), 32'd0);
        chk("mid_rst_res",   32'({oResErr, oResZero, oResCarry, oResult}), 32'd0);
        chk("mid_rst_count", 32'(oOpCount), 32'd0);
        @(posedge iClk); #1;

        // 256 random operations wrap the counter back to zero
        rr_mode = 2;
        run_random(256);
        drain();
        chk("wrap_count", 32'(oOpCount), 32'd0);
        chk("wrap_model", 32'(oOpCount), 32'(model_cnt));

        // Additional mixed traffic
        rr_mode = 2;
        run_random(100);
        drain();
        chk("final_count", 32'(oOpCount), 32'(model_cnt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 1: ALU settle wait in cycles between operand drive and result capture; legal range 1-15.
REQ-002 SHALL have port iClk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port iReset, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports iCmdValid (input, 1) and oCmdReady (output, 1): command handshake.
REQ-005 SHALL have ports iCmdOp (input, 4), iCmdA (input, 8) and iCmdB (input, 8): command opcode and operands.
REQ-006 SHALL have ports oA (output, 8), oB (output, 8) and oOpCode (output, 4): registered drive to the ALU iA/iB/iOpCode.
REQ-007 SHALL have ports iAccu (input, 8), iCarryFlag (input, 1) and iZeroFlag (input, 1): ALU result and flags.
REQ-008 SHALL have ports oResValid (output, 1) and iResReady (input, 1): result handshake.
REQ-009 SHALL have ports oResult (output, 8), oResCarry (output, 1) and oResZero (output, 1): captured result and flags.
REQ-010 SHALL have port oResErr, output, 1: high when the held result came from an unsupported opcode.
REQ-011 SHALL have port oBusy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port oOpCount, output, 8: count of completed result handshakes.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, SETTLE, CAPTURE and HOLD.
REQ-014 SHALL drive oCmdReady = (state==IDLE) | (state==HOLD & iResReady).
REQ-015 SHALL, on iCmdValid & oCmdReady, register iCmdOp/iCmdA/iCmdB into oOpCode/oA/oB and go to ISSUE next cycle.
REQ-016 SHALL hold oA/oB/oOpCode stable from acceptance until the next accepted command.
REQ-017 SHALL move ISSUE -> SETTLE, then stay in SETTLE for SETTLE_CYCLES cycles (down-counter), then go to CAPTURE.
REQ-018 SHALL, in CAPTURE, latch iAccu->oResult, iCarryFlag->oResCarry, iZeroFlag->oResZero and go to HOLD.
REQ-019 SHALL treat opcodes 0000-0111 as supported; for 1000-1111, CAPTURE SHALL load oResult=0, oResCarry=0, oResZero=1, oResErr=1.
REQ-020 SHALL clear oResErr on capture of a supported opcode.
REQ-021 SHALL assert oResValid only in HOLD; oResult/oResCarry/oResZero/oResErr SHALL be stable while oResValid=1.
REQ-022 SHALL, in HOLD with iResReady=1 and no new command, go to IDLE next cycle.
REQ-023 SHALL, in HOLD with iResReady=1 and iCmdValid=1, accept the new command in the same cycle and go directly to ISSUE (back-to-back, no IDLE bubble).
REQ-024 SHALL make accept-to-oResValid latency SETTLE_CYCLES+3 cycles (3+SETTLE_CYCLES-1 edges after the ISSUE edge).
REQ-025 SHALL increment oOpCount on every oResValid & iResReady, wrapping 255->0.
REQ-026 SHALL ignore iCmdValid in ISSUE, SETTLE and CAPTURE (oCmdReady=0; no command loss, the command is held by the sender).
REQ-027 SHALL ignore iResReady outside HOLD.

Reset
REQ-028 SHALL, with iReset=1 at a clock edge, force state=IDLE, oA=oB=0, oOpCode=0, oResult=0, oResCarry=0, oResZero=0, oResErr=0, oResValid=0, oOpCount=0 and the settle counter=0.
REQ-029 SHALL, when reset occurs mid-operation (any state), discard the in-flight command and its result with no count increment.
REQ-030 SHALL take reset priority over every simultaneous handshake.

Verification
REQ-031 SHALL pass this check: reset, then accept op 0101 with A=0xF0, B=0x20 (model ALU) -> oResValid exactly 4 cycles after acceptance (SETTLE_CYCLES=1), oResult=0x10, oResCarry=1, oResZero=0, oOpCount=1 after handshake.
REQ-032 SHALL pass this check: op 0111 with A=0x33, B=0x33 -> oResult=0x00, oResZero=1; hold iResReady=0 for 5 cycles -> outputs stable, oCmdReady=0.
REQ-033 SHALL pass this check: op 1001 with A=0x55 -> oResult=0, oResZero=1, oResErr=1; next op 0000 with A=0xFF, B=0x0F -> oResult=0x0F, oResErr=0.
REQ-034 SHALL pass this check: two commands presented back-to-back with iResReady=1 -> second accepted in the HOLD cycle of the first, no IDLE cycle, oOpCount=2.
REQ-035 SHALL pass this check: iReset pulsed in SETTLE -> next cycle IDLE, oResValid=0, all outputs 0, oOpCount unchanged at 0; 256 completed ops -> oOpCount=0.
